// File: rtl/dcache_victim_buffer_pkg.sv
// Shared definitions for the data-cache victim buffer.
// Holds the victim buffer FSM state type and the default entry count.
package cache_defs;

    localparam int VC_ENTRIES_DEFAULT = 4;

    typedef enum logic [2:0] {
        VC_IDLE       = 3'd0,
        VC_WB         = 3'd1,
        VC_FLUSH_SCAN = 3'd2,
        VC_FLUSH_WB   = 3'd3,
        VC_FLUSH_DONE = 3'd4
    } type_victim_states_e;

endpackage

// File: rtl/dcache_victim_cam.sv
// Combinational address CAM for the victim buffer.
// Ports:
//   valid        per-entry valid bits
//   addr         per-entry line addresses
//   key          address to search for
//   match        key found in a valid entry
//   match_onehot one-hot vector of matching entries
//   match_idx    index of the (lowest) matching entry
//   free_any     at least one entry is invalid
//   free_idx     lowest-index invalid entry
module dcache_victim_cam
    import cache_defs::*;
#(
    parameter int ENTRIES   = VC_ENTRIES_DEFAULT,
    parameter int ADDR_BITS = 26,
    localparam int IDX_W    = $clog2(ENTRIES)
) (
    input  logic [ENTRIES-1:0]                valid,
    input  logic [ENTRIES-1:0][ADDR_BITS-1:0] addr,
    input  logic [ADDR_BITS-1:0]              key,
    output logic                              match,
    output logic [ENTRIES-1:0]                match_onehot,
    output logic [IDX_W-1:0]                  match_idx,
    output logic                              free_any,
    output logic [IDX_W-1:0]                  free_idx
);

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_cmp
            assign match_onehot[gi] = valid[gi] && (addr[gi] == key);
        end
    endgenerate

    // Scanning downward lets the lowest index win both encoders.
    always_comb begin
        match     = |match_onehot;
        free_any  = ~&valid;
        match_idx = '0;
        free_idx  = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (match_onehot[i]) match_idx = IDX_W'(i);
            if (!valid[i])       free_idx  = IDX_W'(i);
        end
    end

endmodule

// File: rtl/dcache_victim_buffer.sv
// Fully-associative victim buffer beside the write-back dcache.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   ins_req_i/addr/data/dirty     insert of an evicted line
//   lookup_req_i/lookup_addr_i    lookup, answered one cycle later
//   take_i                        consume the entry of the last hit
//   victim_hit_o/hit_data_o/hit_dirty_o  registered lookup result
//   busy_o                        inserts are refused
//   wb_req_o/wb_addr_o/wb_data_o/wb_ack_i  write-back to data memory
//   flush_i/flush_done_o          flush walk request and completion pulse
//   count_o                       number of valid entries
module dcache_victim_buffer
    import cache_defs::*;
#(
    parameter int VC_ENTRIES     = VC_ENTRIES_DEFAULT,
    parameter int LINE_ADDR_BITS = 26,
    parameter int LINE_BITS      = 128,
    localparam int IDX_W         = $clog2(VC_ENTRIES),
    localparam int CNT_W         = $clog2(VC_ENTRIES) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ins_req_i,
    input  logic [LINE_ADDR_BITS-1:0] ins_addr_i,
    input  logic [LINE_BITS-1:0]      ins_data_i,
    input  logic                      ins_dirty_i,
    input  logic                      lookup_req_i,
    input  logic [LINE_ADDR_BITS-1:0] lookup_addr_i,
    input  logic                      take_i,
    output logic                      victim_hit_o,
    output logic [LINE_BITS-1:0]      hit_data_o,
    output logic                      hit_dirty_o,
    output logic                      busy_o,
    output logic                      wb_req_o,
    output logic [LINE_ADDR_BITS-1:0] wb_addr_o,
    output logic [LINE_BITS-1:0]      wb_data_o,
    input  logic                      wb_ack_i,
    input  logic                      flush_i,
    output logic                      flush_done_o,
    output logic [CNT_W-1:0]          count_o
);

    logic [VC_ENTRIES-1:0]                     valid_reg;
    logic [VC_ENTRIES-1:0]                     dirty_reg;
    logic [VC_ENTRIES-1:0][LINE_ADDR_BITS-1:0] addr_reg;
    logic [LINE_BITS-1:0]                      data_reg [VC_ENTRIES];

    type_victim_states_e       state_reg;
    logic [IDX_W-1:0]          rep_ptr_reg;
    logic [IDX_W-1:0]          scan_idx_reg;
    logic                      flush_pend_reg;
    logic                      hit_reg;
    logic [IDX_W-1:0]          hit_idx_reg;
    logic [LINE_BITS-1:0]      hit_data_reg;
    logic                      hit_dirty_reg;
    logic [LINE_ADDR_BITS-1:0] wb_addr_reg;
    logic [LINE_BITS-1:0]      wb_data_reg;

    logic                  ins_match, ins_free_any;
    logic [IDX_W-1:0]      ins_match_idx, ins_free_idx;
    logic [VC_ENTRIES-1:0] ins_onehot_unused;
    logic                  lk_match;
    logic [IDX_W-1:0]      lk_match_idx;
    logic [VC_ENTRIES-1:0] lk_onehot_unused;
    logic                  lk_free_any_unused;
    logic [IDX_W-1:0]      lk_free_idx_unused;

    dcache_victim_cam #(.ENTRIES(VC_ENTRIES), .ADDR_BITS(LINE_ADDR_BITS)) u_ins_cam (
        .valid(valid_reg), .addr(addr_reg), .key(ins_addr_i),
        .match(ins_match), .match_onehot(ins_onehot_unused), .match_idx(ins_match_idx),
        .free_any(ins_free_any), .free_idx(ins_free_idx)
    );

    dcache_victim_cam #(.ENTRIES(VC_ENTRIES), .ADDR_BITS(LINE_ADDR_BITS)) u_lk_cam (
        .valid(valid_reg), .addr(addr_reg), .key(lookup_addr_i),
        .match(lk_match), .match_onehot(lk_onehot_unused), .match_idx(lk_match_idx),
        .free_any(lk_free_any_unused), .free_idx(lk_free_idx_unused)
    );

    logic             ins_fire, take_fire, ins_replace, ins_displace;
    logic [IDX_W-1:0] ins_idx;
    logic             ins_dirty_new;
    logic             lk_block, lk_bypass, lk_clobbered, lk_taken, hit_next;
    logic             scan_last;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        ins_fire      = ins_req_i && (state_reg == VC_IDLE);
        take_fire     = take_i && hit_reg;
        ins_replace   = ins_fire && !ins_match && !ins_free_any;
        ins_idx       = ins_match ? ins_match_idx : (ins_free_any ? ins_free_idx : rep_ptr_reg);
        ins_displace  = ins_replace && valid_reg[rep_ptr_reg] && dirty_reg[rep_ptr_reg];
        ins_dirty_new = ins_dirty_i || (ins_match && dirty_reg[ins_match_idx]);
        scan_last     = (scan_idx_reg == IDX_W'(VC_ENTRIES - 1));

        // Lookups see the state as it will be after this cycle's take and insert:
        // the inserted line is forwarded, and a taken or overwritten entry misses.
        lk_block     = (state_reg == VC_FLUSH_SCAN) || (state_reg == VC_FLUSH_WB) ||
                       (state_reg == VC_FLUSH_DONE) || ((state_reg == VC_IDLE) && flush_i);
        lk_bypass    = ins_fire && (lookup_addr_i == ins_addr_i);
        lk_clobbered = ins_fire && (ins_idx == lk_match_idx);
        lk_taken     = take_fire && (hit_idx_reg == lk_match_idx);
        hit_next     = lookup_req_i && !lk_block &&
                       (lk_bypass || (lk_match && !lk_clobbered && !lk_taken));

        count_next = '0;
        for (int i = 0; i < VC_ENTRIES; i++) begin
            count_next = count_next + CNT_W'(valid_reg[i]);
        end
    end

    // Line data behaves like RAM storage: no reset, write on insert only.
    always_ff @(posedge clk) begin
        if (ins_fire) data_reg[ins_idx] <= ins_data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg      <= '0;
            dirty_reg      <= '0;
            addr_reg       <= '0;
            state_reg      <= VC_IDLE;
            rep_ptr_reg    <= '0;
            scan_idx_reg   <= '0;
            flush_pend_reg <= 1'b0;
            hit_reg        <= 1'b0;
            hit_idx_reg    <= '0;
            hit_data_reg   <= '0;
            hit_dirty_reg  <= 1'b0;
            wb_addr_reg    <= '0;
            wb_data_reg    <= '0;
        end else begin
            hit_reg <= hit_next;
            if (hit_next) begin
                hit_idx_reg   <= lk_bypass ? ins_idx : lk_match_idx;
                hit_data_reg  <= lk_bypass ? ins_data_i : data_reg[lk_match_idx];
                hit_dirty_reg <= lk_bypass ? ins_dirty_new : dirty_reg[lk_match_idx];
            end else begin
                hit_data_reg  <= '0;
                hit_dirty_reg <= 1'b0;
            end

            // Take clears first; a same-cycle insert to that slot wins.
            if (take_fire) valid_reg[hit_idx_reg] <= 1'b0;
            if (ins_fire) begin
                valid_reg[ins_idx] <= 1'b1;
                dirty_reg[ins_idx] <= ins_dirty_new;
                addr_reg[ins_idx]  <= ins_addr_i;
            end
            if (ins_replace) rep_ptr_reg <= rep_ptr_reg + IDX_W'(1);

            case (state_reg)
                VC_IDLE: begin
                    if (ins_displace) begin
                        wb_addr_reg    <= addr_reg[rep_ptr_reg];
                        wb_data_reg    <= data_reg[rep_ptr_reg];
                        flush_pend_reg <= flush_i;
                        state_reg      <= VC_WB;
                    end else if (flush_i) begin
                        scan_idx_reg <= '0;
                        state_reg    <= VC_FLUSH_SCAN;
                    end
                end
                VC_WB: begin
                    if (flush_i) flush_pend_reg <= 1'b1;
                    if (wb_ack_i) begin
                        if (flush_pend_reg || flush_i) begin
                            flush_pend_reg <= 1'b0;
                            scan_idx_reg   <= '0;
                            state_reg      <= VC_FLUSH_SCAN;
                        end else begin
                            state_reg <= VC_IDLE;
                        end
                    end
                end
                VC_FLUSH_SCAN: begin
                    valid_reg[scan_idx_reg] <= 1'b0;
                    if (valid_reg[scan_idx_reg] && dirty_reg[scan_idx_reg]) begin
                        wb_addr_reg <= addr_reg[scan_idx_reg];
                        wb_data_reg <= data_reg[scan_idx_reg];
                        state_reg   <= VC_FLUSH_WB;
                    end else if (scan_last) begin
                        state_reg <= VC_FLUSH_DONE;
                    end else begin
                        scan_idx_reg <= scan_idx_reg + IDX_W'(1);
                    end
                end
                VC_FLUSH_WB: begin
                    if (wb_ack_i) begin
                        if (scan_last) begin
                            state_reg <= VC_FLUSH_DONE;
                        end else begin
                            scan_idx_reg <= scan_idx_reg + IDX_W'(1);
                            state_reg    <= VC_FLUSH_SCAN;
                        end
                    end
                end
                VC_FLUSH_DONE: begin
                    rep_ptr_reg <= '0;
                    state_reg   <= VC_IDLE;
                end
                default: state_reg <= VC_IDLE;
            endcase
        end
    end

    assign victim_hit_o = hit_reg;
    assign hit_data_o   = hit_data_reg;
    assign hit_dirty_o  = hit_dirty_reg;
    assign busy_o       = (state_reg != VC_IDLE);
    assign wb_req_o     = (state_reg == VC_WB) || (state_reg == VC_FLUSH_WB);
    assign wb_addr_o    = wb_addr_reg;
    assign wb_data_o    = wb_data_reg;
    assign flush_done_o = (state_reg == VC_FLUSH_DONE);
    assign count_o      = count_next;

endmodule

// File: tb/tb_dcache_victim_buffer.sv
// Randomized self-checking bench for dcache_victim_buffer with an entry-level
// reference model (lists of lines, FIFO replacement pointer, write-back queue).
module tb_dcache_victim_buffer;
    localparam int N = 4;
    localparam int A = 26;
    localparam int D = 128;
    localparam int CW = $clog2(N) + 1;

    logic          clk, rst;
    logic          ins_req_i, ins_dirty_i, lookup_req_i, take_i, wb_ack_i, flush_i;
    logic [A-1:0]  ins_addr_i, lookup_addr_i;
    logic [D-1:0]  ins_data_i;
    logic          victim_hit_o, hit_dirty_o, busy_o, wb_req_o, flush_done_o;
    logic [D-1:0]  hit_data_o, wb_data_o;
    logic [A-1:0]  wb_addr_o;
    logic [CW-1:0] count_o;

    dcache_victim_buffer #(.VC_ENTRIES(N), .LINE_ADDR_BITS(A), .LINE_BITS(D)) dut (
        .clk(clk), .rst(rst),
        .ins_req_i(ins_req_i), .ins_addr_i(ins_addr_i), .ins_data_i(ins_data_i),
        .ins_dirty_i(ins_dirty_i), .lookup_req_i(lookup_req_i), .lookup_addr_i(lookup_addr_i),
        .take_i(take_i), .victim_hit_o(victim_hit_o), .hit_data_o(hit_data_o),
        .hit_dirty_o(hit_dirty_o), .busy_o(busy_o), .wb_req_o(wb_req_o),
        .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_ack_i(wb_ack_i),
        .flush_i(flush_i), .flush_done_o(flush_done_o), .count_o(count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [D-1:0] got, input logic [D-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: a table of lines plus the FIFO victim pointer.
    bit           m_valid [N];
    bit           m_dirty [N];
    logic [A-1:0] m_addr  [N];
    logic [D-1:0] m_data  [N];
    int           m_rep;
    bit           m_last_hit;
    int           m_last_idx;

    function automatic int m_find(input logic [A-1:0] a);
        for (int i = 0; i < N; i++) if (m_valid[i] && m_addr[i] == a) return i;
        return -1;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_valid[i]);
        return c;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
        end
        m_rep = 0;
        m_last_hit = 0;
        m_last_idx = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [D-1:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One cycle of insert/lookup/take, then any write-back it causes.
    // hold<0 picks a random ack delay; rst_wb resets while the write-back is pending.
    task automatic step(input bit ie, input logic [A-1:0] ia, input logic [D-1:0] id,
                        input bit idt, input bit le, input logic [A-1:0] la,
                        input bit te, input int hold, input bit rst_wb);
        int slot, li, h;
        bit matched, disp, nd, exp_hit;
        logic [A-1:0] da;
        logic [D-1:0] dd;
        slot = -1; matched = 0; disp = 0; nd = 0; da = '0; dd = '0;
        if (ie) begin
            slot = m_find(ia);
            matched = (slot >= 0);
            if (!matched) begin
                for (int i = N - 1; i >= 0; i--) if (!m_valid[i]) slot = i;
                if (slot < 0) begin
                    slot = m_rep;
                    disp = m_dirty[slot];
                    da = m_addr[slot];
                    dd = m_data[slot];
                    m_rep = (m_rep + 1) % N;
                end
            end
            nd = idt || (matched && m_dirty[slot]);
        end
        if (te && m_last_hit) m_valid[m_last_idx] = 0;
        if (ie) begin
            m_valid[slot] = 1;
            m_dirty[slot] = nd;
            m_addr[slot] = ia;
            m_data[slot] = id;
        end
        li = le ? m_find(la) : -1;
        exp_hit = (li >= 0);
        m_last_hit = exp_hit;
        m_last_idx = li;

        ins_req_i = ie; ins_addr_i = ia; ins_data_i = id; ins_dirty_i = idt;
        lookup_req_i = le; lookup_addr_i = la; take_i = te;
        tick();
        ins_req_i = 0; lookup_req_i = 0; take_i = 0;
        $display("txn ins=%0d a=%0h d=%0d lk=%0d la=%0h take=%0d exp_hit=%0d cnt=%0d wb=%0d",
                 ie, ia, idt, le, la, te, exp_hit, m_count(), disp);
        check("hit", victim_hit_o, exp_hit);
        if (exp_hit) begin
            check("hit_data", hit_data_o, m_data[li]);
            check("hit_dirty", hit_dirty_o, m_dirty[li]);
        end
        check("count", count_o, m_count());
        check("busy", busy_o, disp);
        check("wb_req", wb_req_o, disp);
        if (disp) begin
            check("wb_addr", wb_addr_o, da);
            check("wb_data", wb_data_o, dd);
            if (rst_wb) begin
                rst = 1;
                tick();
                rst = 0;
                check("rst_wb_req", wb_req_o, 0);
                check("rst_count", count_o, 0);
                check("rst_busy", busy_o, 0);
                m_clear();
                return;
            end
            h = (hold < 0) ? $urandom_range(0, 3) : hold;
            repeat (h) begin
                tick();
                check("wb_hold_req", wb_req_o, 1);
                check("wb_hold_addr", wb_addr_o, da);
                check("wb_hold_data", wb_data_o, dd);
                check("wb_hold_busy", busy_o, 1);
            end
            wb_ack_i = 1;
            tick();
            wb_ack_i = 0;
            check("wb_done_req", wb_req_o, 0);
            check("wb_done_busy", busy_o, 0);
            m_last_hit = 0;
        end
    endtask

    task automatic do_flush();
        logic [A-1:0] qa[$];
        logic [D-1:0] qd[$];
        int cyc, dones, nwb;
        bit clean;
        for (int i = 0; i < N; i++) if (m_valid[i] && m_dirty[i]) begin
            qa.push_back(m_addr[i]);
            qd.push_back(m_data[i]);
        end
        clean = (qa.size() == 0);
        nwb = qa.size();
        flush_i = 1;
        tick();
        flush_i = 0;
        cyc = 1;
        dones = 0;
        for (int it = 0; it < 200 && dones == 0; it++) begin
            if (flush_done_o) begin
                dones++;
            end else if (wb_req_o) begin
                if (qa.size() == 0) begin
                    check("flush_extra_wb", wb_req_o, 0);
                end else begin
                    check("flush_wb_addr", wb_addr_o, qa.pop_front());
                    check("flush_wb_data", wb_data_o, qd.pop_front());
                end
                repeat ($urandom_range(0, 2)) begin
                    tick();
                    cyc++;
                end
                wb_ack_i = 1;
                tick();
                wb_ack_i = 0;
                cyc++;
            end else begin
                tick();
                cyc++;
            end
        end
        $display("txn flush wbs=%0d cycles=%0d", nwb, cyc);
        check("flush_done_seen", dones, 1);
        check("flush_wb_left", qa.size(), 0);
        if (clean) check("flush_len", cyc, N + 1);
        tick();
        check("flush_done_pulse", flush_done_o, 0);
        check("flush_count", count_o, 0);
        check("flush_busy", busy_o, 0);
        m_clear();
    endtask

    initial begin
        logic [A-1:0] a0;
        rst = 1; ins_req_i = 0; ins_addr_i = '0; ins_data_i = '0; ins_dirty_i = 0;
        lookup_req_i = 0; lookup_addr_i = '0; take_i = 0; wb_ack_i = 0; flush_i = 0;
        m_clear();
        tick();
        tick();
        check("rst_hit", victim_hit_o, 0);
        check("rst_hit_data", hit_data_o, 0);
        check("rst_hit_dirty", hit_dirty_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_wb_req", wb_req_o, 0);
        check("rst_wb_addr", wb_addr_o, 0);
        check("rst_wb_data", wb_data_o, 0);
        check("rst_flush_done", flush_done_o, 0);
        check("rst_count", count_o, 0);
        rst = 0;

        // Basic insert, lookup, take, repeat lookup.
        step(1, 'h100, rnd_line(), 0, 0, '0, 0, 0, 0);
        step(0, '0, '0, 0, 1, 'h100, 0, 0, 0);
        step(0, '0, '0, 0, 0, '0, 1, 0, 0);
        step(0, '0, '0, 0, 1, 'h100, 0, 0, 0);

        // Fill dirty, displace with a held ack, then displace entry 1.
        for (int i = 0; i < N; i++) step(1, A'('h10 + i), rnd_line(), 1, 0, '0, 0, 0, 0);
        step(1, 'h14, rnd_line(), 1, 0, '0, 0, 3, 0);
        step(1, 'h15, rnd_line(), 0, 1, 'h12, 0, 0, 0);
        do_flush();

        // Clean displacement.
        for (int i = 0; i < N; i++) step(1, A'('h20 + i), rnd_line(), 0, 0, '0, 0, 0, 0);
        step(1, 'h24, rnd_line(), 0, 1, 'h21, 0, 0, 0);
        step(0, '0, '0, 0, 1, 'h20, 0, 0, 0);
        do_flush();

        // Mixed flush: dirty at 1 and 3.
        for (int i = 0; i < N; i++) step(1, A'('h30 + i), rnd_line(), i[0], 0, '0, 0, 0, 0);
        do_flush();

        // Same-cycle lookup and insert, then overwrite with bypass and take+insert.
        step(1, 'h200, rnd_line(), 0, 1, 'h200, 0, 0, 0);
        step(1, 'h200, rnd_line(), 1, 1, 'h200, 0, 0, 0);
        step(1, 'h201, rnd_line(), 0, 0, '0, 1, 0, 0);
        step(0, '0, '0, 0, 1, 'h200, 0, 0, 0);
        do_flush();

        // Reset while a displacement write-back is pending.
        for (int i = 0; i < N; i++) step(1, A'('h50 + i), rnd_line(), 1, 0, '0, 0, 0, 0);
        step(1, 'h54, rnd_line(), 1, 0, '0, 0, 0, 1);
        step(0, '0, '0, 0, 1, 'h51, 0, 0, 0);

        // Random traffic over a small address pool.
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 99) < 4) begin
                do_flush();
            end else begin
                a0 = A'('h40 + $urandom_range(0, 7));
                step($urandom_range(0, 1) == 1, a0, rnd_line(), $urandom_range(0, 1) == 1,
                     $urandom_range(0, 9) < 6, A'('h40 + $urandom_range(0, 7)),
                     $urandom_range(0, 9) < 3, -1, 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
